// File: rtl/inst_mmu_tlb.sv
// Instruction-side address translator: direct-address mode, direct-map
// windows, and a fully associative 4 KB-page micro-TLB refilled from the
// main TLB. One request per cycle on hits, registered response.

// Tag compare for one micro-TLB entry.
module inst_mmu_tlb_cmp (
  input  logic        vld,
  input  logic [19:0] tag,
  input  logic [19:0] vpn,
  output logic        hit
);
  assign hit = vld && (tag == vpn);
endmodule

module inst_mmu_tlb #(
  parameter int NUM_DMW = 2,
  parameter int ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [31:0]          req_vaddr,
  output logic                 req_ready,
  input  logic [31:0]          crmd,
  input  logic [NUM_DMW*32-1:0] dmw,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic [31:0]          resp_paddr,
  output logic                 resp_uncache,
  output logic                 resp_fault,
  output logic                 refill_req,
  output logic [19:0]          refill_vpn,
  input  logic                 refill_ack,
  input  logic [19:0]          refill_ppn,
  input  logic [1:0]           refill_mat,
  input  logic                 refill_v
);
  localparam int PW = $clog2(ENTRIES);

  typedef enum logic {IDLE, MISS} state_t;
  state_t state, state_nxt;

  logic [ENTRIES-1:0]            ent_v;
  logic [ENTRIES-1:0][19:0]      ent_vpn;
  logic [ENTRIES-1:0][19:0]      ent_ppn;
  logic [ENTRIES-1:0][1:0]       ent_mat;
  logic [ENTRIES-1:0]            hit_vec;
  logic [PW-1:0]                 ptr;
  logic [19:0]                   vpn_q;
  logic [11:0]                   off_q;
  logic                          flushed_q;

  logic [31:0] win [NUM_DMW];
  logic [1:0]  plv;
  logic        accept, install;
  logic        dmw_hit, tlb_hit, any_hit;
  logic [31:0] dmw_paddr, hit_paddr;
  logic        dmw_unc, hit_unc;
  logic [19:0] tlb_ppn;
  logic [1:0]  tlb_mat;

  assign plv       = crmd[1:0];
  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign refill_req = (state == MISS);
  assign refill_vpn = vpn_q;
  // A flush seen at any point of the refill (or in the ack cycle) vetoes the install.
  assign install   = (state == MISS) && refill_ack && refill_v && !flush && !flushed_q;

  for (genvar g = 0; g < NUM_DMW; g++) begin : g_win
    assign win[g] = dmw[32*g +: 32];
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    inst_mmu_tlb_cmp u_cmp (
      .vld (ent_v[e]),
      .tag (ent_vpn[e]),
      .vpn (req_vaddr[31:12]),
      .hit (hit_vec[e])
    );
  end

  // Window match; iterate high to low so the lowest matching index wins.
  always_comb begin
    dmw_hit   = 1'b0;
    dmw_paddr = '0;
    dmw_unc   = 1'b0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      if ((win[i][31:29] == req_vaddr[31:29]) &&
          (((plv == 2'd0) && win[i][0]) || ((plv == 2'd3) && win[i][3]))) begin
        dmw_hit   = 1'b1;
        dmw_paddr = {win[i][27:25], req_vaddr[28:0]};
        dmw_unc   = ~win[i][4];
      end
    end
  end

  // Micro-TLB lookup; tags are unique so OR-combining the hit entries is a mux.
  always_comb begin
    tlb_ppn = '0;
    tlb_mat = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (hit_vec[e]) begin
        tlb_ppn = tlb_ppn | ent_ppn[e];
        tlb_mat = tlb_mat | ent_mat[e];
      end
    end
    tlb_hit = |hit_vec;
  end

  // Priority select: DA, then DMW, then TLB.
  always_comb begin
    any_hit   = 1'b1;
    hit_paddr = req_vaddr;
    hit_unc   = ~crmd[5];
    if (!crmd[4]) begin
      if (dmw_hit) begin
        hit_paddr = dmw_paddr;
        hit_unc   = dmw_unc;
      end else begin
        any_hit   = tlb_hit;
        hit_paddr = {tlb_ppn, req_vaddr[11:0]};
        hit_unc   = (tlb_mat == 2'd0);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !any_hit) state_nxt = MISS;
      MISS: if (refill_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control, response and valid-bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ent_v        <= '0;
      ptr          <= '0;
      vpn_q        <= '0;
      off_q        <= '0;
      flushed_q    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_paddr   <= '0;
      resp_uncache <= 1'b0;
      resp_fault   <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      if (accept) begin
        if (any_hit) begin
          resp_valid   <= 1'b1;
          resp_paddr   <= hit_paddr;
          resp_uncache <= hit_unc;
          resp_fault   <= 1'b0;
        end else begin
          vpn_q     <= req_vaddr[31:12];
          off_q     <= req_vaddr[11:0];
          flushed_q <= 1'b0;
        end
      end
      if (state == MISS) begin
        if (flush) flushed_q <= 1'b1;
        if (refill_ack) begin
          resp_valid <= 1'b1;
          if (refill_v) begin
            resp_paddr   <= {refill_ppn, off_q};
            resp_uncache <= (refill_mat == 2'd0);
            resp_fault   <= 1'b0;
          end else begin
            resp_paddr   <= {vpn_q, off_q};
            resp_uncache <= 1'b1;
            resp_fault   <= 1'b1;
          end
        end
      end
      if (install) begin
        ent_v[ptr] <= 1'b1;
        ptr        <= ptr + 1'b1;
      end
      if (flush) ent_v <= '0;
    end
  end

  // Entry payload; only meaningful when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (install) begin
      ent_vpn[ptr] <= vpn_q;
      ent_ppn[ptr] <= refill_ppn;
      ent_mat[ptr] <= refill_mat;
    end
  end
endmodule

// File: tb/tb_inst_mmu_tlb.sv
module tb_inst_mmu_tlb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_ready;
  logic [31:0] crmd;
  logic [63:0] dmw;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_uncache;
  logic        resp_fault;
  logic        refill_req;
  logic [19:0] refill_vpn;
  logic        refill_ack;
  logic [19:0] refill_ppn;
  logic [1:0]  refill_mat;
  logic        refill_v;

  int tests = 0;
  int fails = 0;

  inst_mmu_tlb #(.NUM_DMW(2), .ENTRIES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_ready(req_ready),
    .crmd(crmd), .dmw(dmw), .flush(flush),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr),
    .resp_uncache(resp_uncache), .resp_fault(resp_fault),
    .refill_req(refill_req), .refill_vpn(refill_vpn),
    .refill_ack(refill_ack), .refill_ppn(refill_ppn),
    .refill_mat(refill_mat), .refill_v(refill_v)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a);
    req_valid = 1'b1;
    req_vaddr = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [19:0] ppn, input logic [1:0] mat, input logic v);
    refill_ack = 1'b1;
    refill_ppn = ppn;
    refill_mat = mat;
    refill_v   = v;
    tick();
    refill_ack = 1'b0;
  endtask

  task automatic hit(input string tag, input logic [31:0] a, input logic [31:0] pa, input logic unc);
    do_req(a);
    chk({tag, ".valid"}, resp_valid, 1);
    chk({tag, ".paddr"}, resp_paddr, pa);
    chk({tag, ".unc"}, resp_uncache, unc);
    chk({tag, ".fault"}, resp_fault, 0);
    chk({tag, ".noreq"}, refill_req, 0);
  endtask

  task automatic miss(input string tag, input logic [31:0] a);
    do_req(a);
    chk({tag, ".novalid"}, resp_valid, 0);
    chk({tag, ".req"}, refill_req, 1);
    chk({tag, ".vpn"}, refill_vpn, a[31:12]);
    chk({tag, ".busy"}, req_ready, 0);
  endtask

  task automatic fill(input string tag, input logic [31:0] a, input logic [19:0] ppn, input logic [1:0] mat);
    miss(tag, a);
    ack(ppn, mat, 1'b1);
    chk({tag, ".fvalid"}, resp_valid, 1);
    chk({tag, ".fpaddr"}, resp_paddr, {ppn, a[11:0]});
    chk({tag, ".func"}, resp_uncache, mat == 2'd0);
    chk({tag, ".ffault"}, resp_fault, 0);
  endtask

  task automatic bad_fill(input string tag, input logic [31:0] a);
    miss(tag, a);
    ack(20'hFFFFF, 2'd1, 1'b0);
    chk({tag, ".bvalid"}, resp_valid, 1);
    chk({tag, ".bpaddr"}, resp_paddr, a);
    chk({tag, ".bunc"}, resp_uncache, 1);
    chk({tag, ".bfault"}, resp_fault, 1);
    chk({tag, ".bready"}, req_ready, 1);
    chk({tag, ".bnoreq"}, refill_req, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; crmd = '0; dmw = '0;
    flush = 1'b0; refill_ack = 1'b0; refill_ppn = '0; refill_mat = '0; refill_v = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.ready", req_ready, 1);
    chk("rst.valid", resp_valid, 0);
    chk("rst.paddr", resp_paddr, 0);
    chk("rst.refill", refill_req, 0);
    chk("rst.vpn", refill_vpn, 0);

    // Direct-address mode, including back-to-back requests.
    crmd = 32'h10;
    hit("da0", 32'h1C00_0000, 32'h1C00_0000, 1'b1);
    crmd = 32'h30;
    req_valid = 1'b1; req_vaddr = 32'h1C00_0040; tick();
    chk("b2b0.paddr", resp_paddr, 32'h1C00_0040);
    chk("b2b0.valid", resp_valid, 1);
    req_vaddr = 32'h2000_0080; tick(); req_valid = 1'b0;
    chk("b2b1.paddr", resp_paddr, 32'h2000_0080);
    chk("b2b1.unc", resp_uncache, 0);
    chk("b2b1.valid", resp_valid, 1);
    tick();
    chk("hold.valid", resp_valid, 0);
    chk("hold.paddr", resp_paddr, 32'h2000_0080);

    // DMW priority and PLV gating.
    crmd = 32'h0;
    dmw  = {32'h8000_0001, 32'h8000_0011};
    hit("dmw0", 32'h8000_1234, 32'h0000_1234, 1'b0);
    crmd = 32'h3;
    bad_fill("plv3", 32'h8000_1234);

    // Miss then hit; ack three cycles after the request.
    crmd = 32'h0; dmw = '0;
    miss("m0", 32'h0040_0ABC);
    tick();
    chk("m0.wait1", refill_req, 1);
    tick();
    chk("m0.wait2", refill_req, 1);
    chk("m0.wait2v", resp_valid, 0);
    ack(20'h12345, 2'd1, 1'b1);
    chk("m0.valid", resp_valid, 1);
    chk("m0.paddr", resp_paddr, 32'h1234_5ABC);
    chk("m0.unc", resp_uncache, 0);
    chk("m0.ready", req_ready, 1);
    // Stray ack while idle must not disturb the entry.
    ack(20'h0DEAD, 2'd0, 1'b1);
    chk("idleack.valid", resp_valid, 0);
    hit("h0", 32'h0040_0123, 32'h1234_5123, 1'b0);

    // Invalid refill installs nothing; the retry misses again.
    bad_fill("inv0", 32'h0050_0010);
    fill("inv1", 32'h0050_0010, 20'h00ABC, 2'd0);
    hit("h1", 32'h0050_0FF0, 32'h00AB_CFF0, 1'b1);

    // Flush in IDLE: same-cycle request sees the old contents.
    flush = 1'b1;
    hit("fl0", 32'h0040_0004, 32'h1234_5004, 1'b0);
    flush = 1'b0;
    bad_fill("fl1", 32'h0040_0004);

    // Replacement wrap over ENTRIES + 1 pages.
    for (int i = 0; i < 5; i++)
      fill($sformatf("wr%0d", i), 32'h0100_0000 + (i << 12), 20'h20000 + i[19:0], 2'd1);
    for (int i = 1; i < 5; i++)
      hit($sformatf("wh%0d", i), 32'h0100_0008 + (i << 12), {20'h20000 + i[19:0], 12'h008}, 1'b0);
    bad_fill("wev", 32'h0100_0008);

    // Flush while waiting for the refill: response delivered, not installed.
    miss("fm", 32'h0300_0000);
    flush = 1'b1; tick(); flush = 1'b0;
    ack(20'h33333, 2'd1, 1'b1);
    chk("fm.valid", resp_valid, 1);
    chk("fm.paddr", resp_paddr, 32'h3333_3000);
    miss("fm2", 32'h0300_0000);

    // Reset mid-refill; a late ack is ignored and the TLB is empty.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr.ready", req_ready, 1);
    chk("mr.refill", refill_req, 0);
    chk("mr.vpn", refill_vpn, 0);
    chk("mr.valid", resp_valid, 0);
    chk("mr.paddr", resp_paddr, 0);
    ack(20'h44444, 2'd1, 1'b1);
    chk("mr.lateack", resp_valid, 0);
    chk("mr.lateready", req_ready, 1);
    bad_fill("mr.empty", 32'h0100_4008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
